stack_op_sequencer: RTL and testbench

- Command-level controller in front of register_stack; posedge-CLK logic feeding a negedge-committed stack.
- Accepts stack commands over a valid/ready handshake and tracks stack depth.
- Rejects commands that would overflow or underflow the stack.
- Expands compound commands (ROT, FLUSH) into multi-cycle sequences of primitive stackOP codes.

---
 rtl/stack_ctrl_pkg.sv | 43 ++++
 rtl/stack_legal_check.sv | 72 +++++++
 rtl/stack_op_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack command sequencer: command codes, the
// primitive stackOP codes understood by register_stack, error codes and the
// sequencer state enum.
package stack_ctrl_pkg;

    // Command codes on the cmd port (10-15 are illegal).
    localparam logic [3:0] CMD_NOP     = 4'd0;
    localparam logic [3:0] CMD_PUSH    = 4'd1;
    localparam logic [3:0] CMD_POP     = 4'd2;
    localparam logic [3:0] CMD_POP2    = 4'd3;
    localparam logic [3:0] CMD_SWAP    = 4'd4;
    localparam logic [3:0] CMD_DUP     = 4'd5;
    localparam logic [3:0] CMD_OVER    = 4'd6;
    localparam logic [3:0] CMD_ROT     = 4'd7;
    localparam logic [3:0] CMD_REPLACE = 4'd8;
    localparam logic [3:0] CMD_FLUSH   = 4'd9;

    // Primitive operations driven to register_stack.
    localparam logic [2:0] SOP_NONE = 3'd0;
    localparam logic [2:0] SOP_PUSH = 3'd1;
    localparam logic [2:0] SOP_REPL = 3'd2;
    localparam logic [2:0] SOP_POP  = 3'd3;
    localparam logic [2:0] SOP_POP2 = 3'd4;
    localparam logic [2:0] SOP_SWAP = 3'd5;

    // Rejection reasons.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNDER   = 2'd1;
    localparam logic [1:0] ERR_OVER    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    // Sequencer state: ST_Rn / ST_FLUSH name the op currently on stack_op.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_R1,
        ST_R2,
        ST_R3,
        ST_R4,
        ST_R5,
        ST_FLUSH
    } seq_state_e;

endpackage

// File: rtl/stack_legal_check.sv
// Combinational legality check for one stack command against the current
// depth. Produces ok, the rejection reason and the net depth change of the
// single-op commands (two's complement in DEPTH_W bits; 0 for NOP/ROT/FLUSH).
module stack_legal_check
    import stack_ctrl_pkg::*;
#(
    parameter int STACK_SIZE = 32,
    parameter int DEPTH_W    = $clog2(STACK_SIZE + 1)
) (
    input  logic [3:0]         cmd,
    input  logic [DEPTH_W-1:0] depth,
    output logic               ok,
    output logic [1:0]         err_code,
    output logic [DEPTH_W-1:0] depth_delta
);

    localparam logic [DEPTH_W-1:0] D_FULL   = DEPTH_W'(STACK_SIZE);
    localparam logic [DEPTH_W-1:0] D_ONE    = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] D_TWO    = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] D_THREE  = DEPTH_W'(3);
    localparam logic [DEPTH_W-1:0] D_MINUS1 = DEPTH_W'(-1);
    localparam logic [DEPTH_W-1:0] D_MINUS2 = DEPTH_W'(-2);

    // Underflow is reported ahead of overflow when both could apply.
    always_comb begin
        err_code    = ERR_NONE;
        depth_delta = '0;
        case (cmd)
            CMD_NOP, CMD_FLUSH: begin
                err_code = ERR_NONE;
            end
            CMD_PUSH: begin
                if (depth >= D_FULL) err_code = ERR_OVER;
                depth_delta = D_ONE;
            end
            CMD_DUP: begin
                if (depth < D_ONE)        err_code = ERR_UNDER;
                else if (depth >= D_FULL) err_code = ERR_OVER;
                depth_delta = D_ONE;
            end
            CMD_OVER: begin
                if (depth < D_TWO)        err_code = ERR_UNDER;
                else if (depth >= D_FULL) err_code = ERR_OVER;
                depth_delta = D_ONE;
            end
            CMD_POP: begin
                if (depth < D_ONE) err_code = ERR_UNDER;
                depth_delta = D_MINUS1;
            end
            CMD_REPLACE: begin
                if (depth < D_TWO) err_code = ERR_UNDER;
                depth_delta = D_MINUS1;
            end
            CMD_POP2: begin
                if (depth < D_TWO) err_code = ERR_UNDER;
                depth_delta = D_MINUS2;
            end
            CMD_SWAP: begin
                if (depth < D_TWO) err_code = ERR_UNDER;
            end
            CMD_ROT: begin
                if (depth < D_THREE) err_code = ERR_UNDER;
            end
            default: begin
                err_code = ERR_ILLEGAL;
            end
        endcase
        ok = (err_code == ERR_NONE);
        if (!ok) depth_delta = '0;
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Command-level controller in front of register_stack. Handshake: a command
// transfers on a posedge where cmd_valid && cmd_ready; cmd_ready is high in
// idle and in the final-op cycle of every command, low in the other ROT and
// FLUSH cycles. All outputs are registered so stack_op/stack_w are settled
// well before the negedge on which register_stack commits.
module stack_op_sequencer
    import stack_ctrl_pkg::*;
#(
    parameter int STACK_SIZE = 32,
    parameter int DATA_W     = 16,
    parameter int DEPTH_W    = $clog2(STACK_SIZE + 1)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd,
    input  logic [DATA_W-1:0]  cmd_data,
    input  logic [DATA_W-1:0]  stk_a,
    input  logic [DATA_W-1:0]  stk_b,
    output logic [2:0]         stack_op,
    output logic [DATA_W-1:0]  stack_w,
    output logic [DEPTH_W-1:0] depth,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output seq_state_e         dbg_state
);

    localparam logic [DEPTH_W-1:0] D_FULL = DEPTH_W'(STACK_SIZE);
    localparam logic [DEPTH_W-1:0] D_ONE  = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] D_TWO  = DEPTH_W'(2);

    seq_state_e         state_q, state_d;
    logic [2:0]         stack_op_q, stack_op_d;
    logic [DATA_W-1:0]  stack_w_q, stack_w_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [DATA_W-1:0]  y_q, y_d;

    logic               chk_ok;
    logic [1:0]         chk_err;
    logic [DEPTH_W-1:0] chk_delta;

    logic [2:0]         flush_op;
    logic [DEPTH_W-1:0] flush_dec;
    logic               flush_last;

    stack_legal_check #(
        .STACK_SIZE (STACK_SIZE),
        .DEPTH_W    (DEPTH_W)
    ) u_legal (
        .cmd         (cmd),
        .depth       (depth_q),
        .ok          (chk_ok),
        .err_code    (chk_err),
        .depth_delta (chk_delta)
    );

    // Next FLUSH step from the remaining depth: pop two while possible, then one.
    always_comb begin
        flush_op   = SOP_NONE;
        flush_dec  = '0;
        flush_last = 1'b1;
        if (depth_q >= D_TWO) begin
            flush_op   = SOP_POP2;
            flush_dec  = D_TWO;
            flush_last = (depth_q == D_TWO);
        end else if (depth_q == D_ONE) begin
            flush_op  = SOP_POP;
            flush_dec = D_ONE;
        end
    end

    // Next-state and registered-output logic: continue a sequence, or accept.
    always_comb begin
        state_d     = ST_IDLE;
        stack_op_d  = SOP_NONE;
        stack_w_d   = '0;
        depth_d     = depth_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        cmd_ready_d = 1'b1;
        x_d         = x_q;
        y_d         = y_q;

        if (!cmd_ready_q) begin
            // Mid-sequence: no command can be accepted this cycle.
            case (state_q)
                ST_R1: begin
                    y_d         = stk_a;
                    stack_op_d  = SOP_POP;
                    depth_d     = depth_q - D_ONE;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_R2;
                end
                ST_R2: begin
                    stack_op_d  = SOP_PUSH;
                    stack_w_d   = x_q;
                    depth_d     = depth_q + D_ONE;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_R3;
                end
                ST_R3: begin
                    stack_op_d  = SOP_SWAP;
                    busy_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_R4;
                end
                ST_R4: begin
                    stack_op_d = SOP_PUSH;
                    stack_w_d  = y_q;
                    depth_d    = depth_q + D_ONE;
                    busy_d     = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_R5;
                end
                ST_FLUSH: begin
                    stack_op_d  = flush_op;
                    depth_d     = depth_q - flush_dec;
                    busy_d      = 1'b1;
                    done_d      = flush_last;
                    cmd_ready_d = flush_last;
                    state_d     = ST_FLUSH;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (cmd_valid) begin
            // Accept edge: legality uses the current depth; first op goes out now.
            err_code_d = chk_err;
            if (!chk_ok) begin
                err_d  = 1'b1;
                done_d = 1'b1;
            end else begin
                depth_d = depth_q + chk_delta;
                done_d  = 1'b1;
                case (cmd)
                    CMD_PUSH: begin
                        stack_op_d = SOP_PUSH;
                        stack_w_d  = cmd_data;
                    end
                    CMD_DUP: begin
                        stack_op_d = SOP_PUSH;
                        stack_w_d  = stk_a;
                    end
                    CMD_OVER: begin
                        stack_op_d = SOP_PUSH;
                        stack_w_d  = stk_b;
                    end
                    CMD_POP:  stack_op_d = SOP_POP;
                    CMD_POP2: stack_op_d = SOP_POP2;
                    CMD_SWAP: stack_op_d = SOP_SWAP;
                    CMD_REPLACE: begin
                        stack_op_d = SOP_REPL;
                        stack_w_d  = cmd_data;
                    end
                    CMD_ROT: begin
                        x_d         = stk_a;
                        stack_op_d  = SOP_POP;
                        depth_d     = depth_q - D_ONE;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                        cmd_ready_d = 1'b0;
                        state_d     = ST_R1;
                    end
                    CMD_FLUSH: begin
                        stack_op_d  = flush_op;
                        depth_d     = depth_q - flush_dec;
                        busy_d      = (flush_op != SOP_NONE);
                        done_d      = flush_last;
                        cmd_ready_d = flush_last;
                        state_d     = (flush_op != SOP_NONE) ? ST_FLUSH : ST_IDLE;
                    end
                    default: begin
                        stack_op_d = SOP_NONE;
                    end
                endcase
            end
        end
    end

    // State and output registers; async reset drops any sequence in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            stack_op_q  <= SOP_NONE;
            stack_w_q   <= '0;
            depth_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            cmd_ready_q <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            stack_op_q  <= stack_op_d;
            stack_w_q   <= stack_w_d;
            depth_q     <= depth_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cmd_ready_q <= cmd_ready_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign stack_op  = stack_op_q;
    assign stack_w   = stack_w_q;
    assign depth     = depth_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign dbg_state = state_q;

    // The legality checks keep the depth counter inside the physical stack.
    depth_in_range: assert property (@(posedge CLK) disable iff (!RST_N) depth_q <= D_FULL);

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer with a behavioural register_stack that commits
// on the negedge. Directed command vectors, hand-computed expectations.
module tb_stack_op_sequencer;
    import stack_ctrl_pkg::*;

    localparam int STACK_SIZE = 32;
    localparam int DATA_W     = 16;
    localparam int DEPTH_W    = $clog2(STACK_SIZE + 1);

    logic               CLK = 1'b0;
    logic               RST_N;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [3:0]         cmd;
    logic [DATA_W-1:0]  cmd_data;
    logic [DATA_W-1:0]  stk_a;
    logic [DATA_W-1:0]  stk_b;
    logic [2:0]         stack_op;
    logic [DATA_W-1:0]  stack_w;
    logic [DEPTH_W-1:0] depth;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         err_code;
    seq_state_e         dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];
    int rot_depth[5] = '{2, 1, 2, 2, 3};

    stack_op_sequencer #(
        .STACK_SIZE (STACK_SIZE),
        .DATA_W     (DATA_W),
        .DEPTH_W    (DEPTH_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_data  (cmd_data),
        .stk_a     (stk_a),
        .stk_b     (stk_b),
        .stack_op  (stack_op),
        .stack_w   (stack_w),
        .depth     (depth),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 CLK = ~CLK;

    // register_stack model: commits the driven op on the negedge
    logic [DATA_W-1:0] stk_mem [0:STACK_SIZE-1] = '{default: '0};
    assign stk_a = stk_mem[0];
    assign stk_b = stk_mem[1];

    always @(negedge CLK) begin
        case (stack_op)
            SOP_PUSH: begin
                for (int i = STACK_SIZE - 1; i > 0; i--) stk_mem[i] <= stk_mem[i-1];
                stk_mem[0] <= stack_w;
            end
            SOP_REPL: begin
                stk_mem[0] <= stack_w;
                for (int i = 1; i < STACK_SIZE - 1; i++) stk_mem[i] <= stk_mem[i+1];
                stk_mem[STACK_SIZE-1] <= '0;
            end
            SOP_POP: begin
                for (int i = 0; i < STACK_SIZE - 1; i++) stk_mem[i] <= stk_mem[i+1];
                stk_mem[STACK_SIZE-1] <= '0;
            end
            SOP_POP2: begin
                for (int i = 0; i < STACK_SIZE - 2; i++) stk_mem[i] <= stk_mem[i+2];
                stk_mem[STACK_SIZE-2] <= '0;
                stk_mem[STACK_SIZE-1] <= '0;
            end
            SOP_SWAP: begin
                stk_mem[0] <= stk_mem[1];
                stk_mem[1] <= stk_mem[0];
            end
            default: begin
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next posedge: outputs of that edge are settled.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [DATA_W-1:0] d);
        cmd_valid = 1'b1;
        cmd       = c;
        cmd_data  = d;
    endtask

    task automatic release_cmd();
        cmd_valid = 1'b0;
        cmd       = CMD_NOP;
        cmd_data  = '0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        release_cmd();
        repeat (3) step();

        // Reset state
        check("rst_op", stack_op, SOP_NONE);
        check("rst_w", stack_w, 0);
        check("rst_depth", depth, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, ERR_NONE);
        check("rst_ready", cmd_ready, 1);
        RST_N = 1'b1;

        // Three back-to-back pushes
        drive(CMD_PUSH, 16'h1111); step();
        check("push1_op", stack_op, SOP_PUSH);
        check("push1_w", stack_w, 16'h1111);
        check("push1_done", done, 1);
        drive(CMD_PUSH, 16'h2222); step();
        check("push2_op", stack_op, SOP_PUSH);
        check("push2_w", stack_w, 16'h2222);
        drive(CMD_PUSH, 16'h3333); step();
        check("push3_op", stack_op, SOP_PUSH);
        check("push3_depth", depth, 3);
        release_cmd(); step();
        check("push_idle_op", stack_op, SOP_NONE);
        check("push_stk_a", stk_a, 16'h3333);
        check("push_stk_b", stk_b, 16'h2222);
        check("push_err", err_code, ERR_NONE);

        // ROT [3333,2222,1111] -> [2222,1111,3333]
        drive(CMD_ROT, '0); step(); release_cmd();
        exp_q.push_back(SOP_POP);
        exp_q.push_back(SOP_POP);
        exp_q.push_back(SOP_PUSH);
        exp_q.push_back(SOP_SWAP);
        exp_q.push_back(SOP_PUSH);
        for (int k = 0; k < 5; k++) begin
            check("rot_op", stack_op, exp_q.pop_front());
            check("rot_ready", cmd_ready, (k == 4));
            check("rot_done", done, (k == 4));
            check("rot_busy", busy, 1);
            check("rot_depth", depth, rot_depth[k]);
            step();
        end
        check("rot_top", stk_a, 16'h2222);
        check("rot_second", stk_b, 16'h1111);
        check("rot_third", stk_mem[2], 16'h3333);
        check("rot_end_depth", depth, 3);
        check("rot_end_busy", busy, 0);

        // Down to depth 1, then POP2 underflow, then a normal PUSH
        drive(CMD_POP, '0); step();
        check("pop_a_op", stack_op, SOP_POP);
        step();
        check("pop_b_op", stack_op, SOP_POP);
        check("pop_depth", depth, 1);
        drive(CMD_POP2, '0); step();
        check("pop2u_op", stack_op, SOP_NONE);
        check("pop2u_err", err, 1);
        check("pop2u_code", err_code, ERR_UNDER);
        check("pop2u_done", done, 1);
        check("pop2u_depth", depth, 1);
        drive(CMD_PUSH, 16'hAAAA); step();
        check("pushA_op", stack_op, SOP_PUSH);
        check("pushA_w", stack_w, 16'hAAAA);
        check("pushA_err", err, 0);
        check("pushA_code", err_code, ERR_NONE);
        check("pushA_depth", depth, 2);

        // Fill to full, DUP overflow, then FLUSH in 16 POP2 cycles
        for (int i = 0; i < 30; i++) begin
            drive(CMD_PUSH, DATA_W'(16'h0100 + i));
            step();
        end
        check("full_depth", depth, STACK_SIZE);
        drive(CMD_DUP, '0); step();
        check("dupo_op", stack_op, SOP_NONE);
        check("dupo_code", err_code, ERR_OVER);
        check("dupo_err", err, 1);
        check("dupo_depth", depth, STACK_SIZE);
        drive(CMD_FLUSH, '0); step(); release_cmd();
        for (int k = 0; k < 16; k++) begin
            check("flush32_op", stack_op, SOP_POP2);
            check("flush32_depth", depth, 32 - 2 * (k + 1));
            check("flush32_done", done, (k == 15));
            check("flush32_ready", cmd_ready, (k == 15));
            step();
        end
        check("flush32_end_op", stack_op, SOP_NONE);
        check("flush32_end_depth", depth, 0);
        check("flush32_stk_a", stk_a, 0);

        // Mixed single ops streamed back to back, ending at depth 5
        for (int i = 0; i < 5; i++) begin
            drive(CMD_PUSH, DATA_W'(16'h0050 + i));
            step();
        end
        drive(CMD_OVER, '0); step();
        check("over_op", stack_op, SOP_PUSH);
        check("over_w", stack_w, 16'h0053);
        drive(CMD_SWAP, '0); step();
        check("swap_op", stack_op, SOP_SWAP);
        check("swap_depth", depth, 6);
        drive(CMD_DUP, '0); step();
        check("dup_w", stack_w, 16'h0054);
        check("dup_depth", depth, 7);
        drive(CMD_REPLACE, 16'hBEEF); step();
        check("repl_op", stack_op, SOP_REPL);
        check("repl_w", stack_w, 16'hBEEF);
        check("repl_depth", depth, 6);
        drive(CMD_POP, '0); step();
        check("pop5_depth", depth, 5);
        release_cmd(); step();
        check("mix_top", stk_a, 16'h0053);
        check("mix_second", stk_b, 16'h0053);
        check("mix_third", stk_mem[2], 16'h0052);

        // FLUSH at depth 5: ops 4,4,3
        drive(CMD_FLUSH, '0); step(); release_cmd();
        exp_q.push_back(SOP_POP2);
        exp_q.push_back(SOP_POP2);
        exp_q.push_back(SOP_POP);
        for (int k = 0; k < 3; k++) begin
            check("flush5_op", stack_op, exp_q.pop_front());
            check("flush5_done", done, (k == 2));
            check("flush5_depth", depth, (k == 0) ? 3 : (k == 1) ? 1 : 0);
            step();
        end

        // Illegal command 12
        drive(4'd12, '0); step(); release_cmd();
        check("ill_op", stack_op, SOP_NONE);
        check("ill_code", err_code, ERR_ILLEGAL);
        check("ill_err", err, 1);
        check("ill_done", done, 1);
        step();
        check("ill_err_pulse", err, 0);
        check("ill_code_held", err_code, ERR_ILLEGAL);

        // FLUSH on an empty stack: no op, done only
        drive(CMD_FLUSH, '0); step(); release_cmd();
        check("flush0_op", stack_op, SOP_NONE);
        check("flush0_done", done, 1);
        check("flush0_busy", busy, 0);
        check("flush0_code", err_code, ERR_NONE);

        // Async reset during ROT step R3
        drive(CMD_PUSH, 16'h7001); step();
        drive(CMD_PUSH, 16'h7002); step();
        drive(CMD_PUSH, 16'h7003); step();
        drive(CMD_ROT, '0); step(); release_cmd();
        step();
        step();
        check("r3_op", stack_op, SOP_PUSH);
        check("r3_w", stack_w, 16'h7003);
        #2 RST_N = 1'b0;
        #1;
        check("arst_op", stack_op, SOP_NONE);
        check("arst_depth", depth, 0);
        check("arst_busy", busy, 0);
        #2 RST_N = 1'b1;
        step();
        check("arst_ready", cmd_ready, 1);
        drive(CMD_PUSH, 16'hBEEF); step(); release_cmd();
        check("post_op", stack_op, SOP_PUSH);
        check("post_w", stack_w, 16'hBEEF);
        check("post_depth", depth, 1);
        step();
        check("post_top", stk_a, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
